// File: rtl/dco_tune_ctrl_pkg.sv
// Shared constants for the DCO fine-tune path: FSM encoding, Q-format split and MASH output width.
package dco_tune_ctrl_pkg;

  localparam int Q_FRAC_W = 8;
  localparam int MASH_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRACK  = 2'd2
  } state_t;

endpackage

// File: rtl/dco_tune_ctrl_mash.sv
// MASH 1-1 dither core: two cascaded FRAC_W-bit accumulators, y = c1 + c2 - c2_d in -1..+2.
// y is combinational on the current frac so the caller can use it in the same cycle.
module mash11_core
  import dco_tune_ctrl_pkg::*;
#(
  parameter int FRAC_W = Q_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [FRAC_W-1:0]        frac,
  output logic signed [MASH_W-1:0] y
);

  logic [FRAC_W-1:0] acc1;
  logic [FRAC_W-1:0] acc2;
  logic              c2_d;
  logic [FRAC_W:0]   s1;
  logic [FRAC_W:0]   s2;

  // Second stage integrates the already-updated first-stage residue.
  always_comb begin
    s1 = {1'b0, acc1} + {1'b0, frac};
    s2 = {1'b0, acc2} + {1'b0, s1[FRAC_W-1:0]};
    y  = MASH_W'(s1[FRAC_W]) + MASH_W'(s2[FRAC_W]) - MASH_W'(c2_d);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc1 <= '0;
      acc2 <= '0;
      c2_d <= 1'b0;
    end else if (en) begin
      acc1 <= s1[FRAC_W-1:0];
      acc2 <= s2[FRAC_W-1:0];
      c2_d <= s2[FRAC_W];
    end
  end

endmodule

// File: rtl/dco_tune_ctrl.sv
// Loop-filter output to DCO fine code: offset + integer part + MASH 1-1 dither, saturated.
// Settle FSM parks the DCO at the centre code after enable; one-cycle latency per accepted sample.
module dco_tune_ctrl
  import dco_tune_ctrl_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = Q_FRAC_W,
  parameter int CODE_W = 7,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] filt_in,
  input  logic              filt_vld,
  input  logic [CODE_W-1:0] fine_offset,
  input  logic [CNT_W-1:0]  settle_cycles,
  output logic [CODE_W-1:0] dco_code,
  output logic              dco_vld,
  output logic [1:0]        state,
  output logic              sat_flag
);

  localparam int IP_W  = DATA_W - FRAC_W;
  localparam int SUM_W = CODE_W + IP_W + 2;
  localparam logic [SUM_W-1:0] CODE_MAX = SUM_W'((1 << CODE_W) - 1);

  state_t                    st;
  logic [CNT_W-1:0]          cnt;
  logic                      settle_done;
  logic                      accept;
  logic                      mash_clr;
  logic signed [MASH_W-1:0]  y;
  logic [IP_W-1:0]           ip;
  logic [SUM_W-1:0]          sum;
  logic [CODE_W-1:0]         code_next;
  logic                      clip;

  assign state       = st;
  assign ip          = filt_in[DATA_W-1:FRAC_W];
  assign accept      = (st == ST_TRACK) && enable && filt_vld;
  assign mash_clr    = (st == ST_IDLE) || !enable;
  // A zero settle length still spends exactly one cycle in SETTLE.
  assign settle_done = (settle_cycles == '0) || (cnt == settle_cycles - CNT_W'(1));

  mash11_core #(
    .FRAC_W (FRAC_W)
  ) u_mash (
    .clk  (clk),
    .rst  (rst),
    .clr  (mash_clr),
    .en   (accept),
    .frac (filt_in[FRAC_W-1:0]),
    .y    (y)
  );

  // Wide enough that offset + ip + y never wraps; clipping is decided on the true value.
  always_comb begin
    sum = {{(SUM_W-CODE_W){1'b0}}, fine_offset}
        + {{(SUM_W-IP_W){ip[IP_W-1]}}, ip}
        + {{(SUM_W-MASH_W){y[MASH_W-1]}}, y};
    code_next = sum[CODE_W-1:0];
    clip      = 1'b0;
    if (sum[SUM_W-1]) begin
      code_next = '0;
      clip      = 1'b1;
    end else if (sum > CODE_MAX) begin
      code_next = '1;
      clip      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      cnt      <= '0;
      dco_code <= '0;
      dco_vld  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      dco_vld <= 1'b0;
      if (!enable) begin
        st       <= ST_IDLE;
        cnt      <= '0;
        dco_code <= fine_offset;
        sat_flag <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            st       <= ST_SETTLE;
            cnt      <= '0;
            dco_code <= fine_offset;
            sat_flag <= 1'b0;
          end
          ST_SETTLE: begin
            dco_code <= fine_offset;
            if (settle_done) st <= ST_TRACK;
            else             cnt <= cnt + CNT_W'(1);
          end
          ST_TRACK: begin
            if (filt_vld) begin
              dco_code <= code_next;
              dco_vld  <= 1'b1;
              if (clip) sat_flag <= 1'b1;
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed bench for dco_tune_ctrl: per-cycle comparison against an arithmetic model plus literal checks.
module tb_dco_tune_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] filt_in;
  logic        filt_vld;
  logic [6:0]  fine_offset;
  logic [9:0]  settle_cycles;
  logic [6:0]  dco_code;
  logic        dco_vld;
  logic [1:0]  state;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  // Model state: phase 0/1/2, cycles spent settling, MASH accumulators as plain integers.
  int m_state = 0, m_code = 0, m_vld = 0, m_sat = 0, m_settled = 0;
  int a1 = 0, a2 = 0, c2d = 0;

  int seq[8];

  always #5 clk = ~clk;

  dco_tune_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .filt_in       (filt_in),
    .filt_vld      (filt_vld),
    .fine_offset   (fine_offset),
    .settle_cycles (settle_cycles),
    .dco_code      (dco_code),
    .dco_vld       (dco_vld),
    .state         (state),
    .sat_flag      (sat_flag)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int sc, fr, ip, s, c1, c2, y, sum;
    logic signed [7:0] ipb;
    if (rst) begin
      m_state = 0; m_code = 0; m_vld = 0; m_sat = 0; m_settled = 0;
      a1 = 0; a2 = 0; c2d = 0;
    end else if (!enable) begin
      m_state = 0; m_code = fine_offset; m_vld = 0; m_sat = 0;
      a1 = 0; a2 = 0; c2d = 0;
    end else begin
      m_vld = 0;
      if (m_state == 0) begin
        m_state = 1; m_settled = 0; m_code = fine_offset; m_sat = 0;
        a1 = 0; a2 = 0; c2d = 0;
      end else if (m_state == 1) begin
        sc = settle_cycles;
        if (sc == 0) sc = 1;
        m_code = fine_offset;
        m_settled++;
        if (m_settled >= sc) m_state = 2;
      end else if (filt_vld) begin
        ipb = filt_in[15:8];
        ip  = ipb;
        fr  = filt_in[7:0];
        s   = a1 + fr;  c1 = s / 256; a1 = s % 256;
        s   = a2 + a1;  c2 = s / 256; a2 = s % 256;
        y   = c1 + c2 - c2d;
        c2d = c2;
        sum = fine_offset + ip + y;
        if (sum < 0)        begin m_code = 0;   m_sat = 1; end
        else if (sum > 127) begin m_code = 127; m_sat = 1; end
        else                m_code = sum;
        m_vld = 1;
      end
    end
    #1;
    chk("cyc state", state, m_state);
    chk("cyc dco_code", dco_code, m_code);
    chk("cyc dco_vld", dco_vld, m_vld);
    chk("cyc sat_flag", sat_flag, m_sat);
  end

  // Raise enable and count SETTLE cycles until TRACK appears; dco_vld must stay low throughout.
  task automatic enter_track(input int exp_settle, input string tag);
    int n = 0;
    int v = 0;
    enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (dco_vld) v++;
      if (state == 2) break;
      if (state == 1) n++;
    end
    chk({tag, " reached TRACK"}, state, 2);
    chk({tag, " settle cycles"}, n, exp_settle);
    chk({tag, " dco_vld in settle"}, v, 0);
  endtask

  initial begin
    int lo, hi, tot, cnt, bad, v;
    rst = 1'b1; enable = 1'b0; filt_in = '0; filt_vld = 1'b0;
    fine_offset = 7'd64; settle_cycles = 10'd5;

    // Reset
    @(negedge clk);
    chk("reset code", dco_code, 0);
    chk("reset state", state, 0);
    @(negedge clk);
    chk("reset code 2", dco_code, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle code offset", dco_code, 64);
    chk("idle state", state, 0);

    // Settle with strobes present, then first tracked sample
    filt_vld = 1'b1; filt_in = 16'h0100;
    enter_track(5, "settle5");
    @(negedge clk);
    chk("first track vld", dco_vld, 1);
    chk("first track code", dco_code, 65);
    enable = 1'b0; settle_cycles = 10'd0;
    @(negedge clk);
    enter_track(1, "settle0");
    enable = 1'b0; filt_vld = 1'b0; settle_cycles = 10'd5;
    @(negedge clk);

    // Dither 1.5 LSB for 256 samples
    enter_track(5, "dither");
    filt_in = 16'h0180;
    lo = 1000; hi = -1; tot = 0; cnt = 0;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0 && dco_vld) begin
        if (cnt < 8) seq[cnt] = dco_code;
        if (dco_code < lo) lo = dco_code;
        if (dco_code > hi) hi = dco_code;
        tot += dco_code;
        cnt++;
      end
      filt_vld = (i < 256);
    end
    chk("dither count", cnt, 256);
    chk("dither min ok", int'(lo >= 64), 1);
    chk("dither max ok", int'(hi <= 67), 1);
    chk("dither sum ok", int'(tot >= 16768 && tot <= 16769), 1);
    chk("dither s0", seq[0], 65);
    chk("dither s1", seq[1], 66);
    chk("dither s2", seq[2], 66);
    chk("dither s3", seq[3], 65);

    filt_in = 16'h0100; filt_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dco_code != 65) bad++;
    end
    chk("const 65 deviations", bad, 0);

    // Saturation both ways, sticky flag
    filt_in = 16'h7F00;
    @(negedge clk);
    chk("sat hi code", dco_code, 127);
    chk("sat hi flag", sat_flag, 1);
    filt_in = 16'h8000;
    @(negedge clk);
    chk("sat lo code", dco_code, 0);
    filt_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat sticky", sat_flag, 1);
    chk("sat hold code", dco_code, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("sat cleared", sat_flag, 0);

    // Low-side clip with a small offset
    fine_offset = 7'd3; filt_in = 16'hF800;
    enter_track(5, "lowclip");
    filt_vld = 1'b1;
    @(negedge clk);
    chk("lowclip code", dco_code, 0);
    chk("lowclip flag", sat_flag, 1);
    filt_vld = 1'b0; enable = 1'b0; fine_offset = 7'd64;
    @(negedge clk);

    // Abort mid-TRACK, then MASH must restart from zero
    filt_in = 16'h0180;
    enter_track(5, "abort");
    filt_vld = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort state", state, 0);
    chk("abort vld", dco_vld, 0);
    chk("abort code", dco_code, 64);
    filt_vld = 1'b0;
    enter_track(5, "reenable");
    filt_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("restart seq %0d", i), dco_code, seq[i]);
    end

    // Sparse strobes every 4th cycle
    filt_vld = 1'b0; filt_in = 16'h0140;
    @(negedge clk);
    v = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk($sformatf("sparse vld %0d", i), dco_vld, int'(i % 4 == 1));
        if (dco_vld) v++;
      end
      filt_vld = (i < 16) && (i % 4 == 0);
      @(negedge clk);
    end
    chk("sparse count", v, 4);

    filt_vld = 1'b0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
